bus_cycle_ctrl: RTL and testbench
=================================

Name: bus_cycle_ctrl

Overview:
Machine-cycle / T-state sequencer for the 8085 external bus. It accepts one bus-cycle request at a time from the decoding block. It drives ALE, RDn, WRn, IOMn, S0, S1 and INTAn, plus the multiplexed AD and high-address output enables. It handles READY wait states and HOLD/HLDA bus handover, replacing the ad-hoc control-word bit decoding in the top level.

Parameters:
MAX_WAIT, 0, max consecutive TW states before T3 is forced; 0 = unlimited
WAIT_CNT_W, 4, width of the wait counter; MAX_WAIT must be < 2**WAIT_CNT_W

Ports:
phi1  in  1  single system clock; all state changes on rising edge
resetn  in  1  synchronous, active-low reset
cyc_req  in  1  request a bus cycle; held with type/addr/wdata until cyc_ack
cyc_type  in  3  mcycle_t: OF=0, MR=1, MW=2, IOR=3, IOW=4, INA=5; 6,7 reserved
cyc_long  in  1  OF/INA only: add T5,T6 (6-T cycle)
cyc_addr  in  16  cycle address
cyc_wdata  in  8  write data for MW/IOW
cyc_ack  out  1  high during T1: request latched
cyc_done  out  1  one-cycle pulse in the cycle after the final T-state
rdata  out  8  data captured from ad_in for OF/MR/IOR/INA
wait_timeout  out  1  sticky; set when MAX_WAIT forces T3; cleared by reset
ad_in  in  8  AD[7:0] pin input
ad_out  out  8  AD[7:0] pin output value
ad_oe  out  1  AD[7:0] output enable
haddress  out  8  A[15:8]
addr_oe  out  1  A[15:8] output enable
ALE  out  1  address latch enable
RDn, WRn, INTAn  out  1 each  active-low strobes
IOMn, S1, S0  out  1 each  status
ready  in  1  READY pin
hold  in  1  HOLD pin (async; one sync flop inside)
hlda  out  1  hold acknowledge
tstate  out  4  tstate_t for debug/trace

Behaviour:
- Clock and reset: one clock (phi1); resetn is synchronous and active-low.
- All outputs are registered.
- Reset values: state IDLE; ALE=0; RDn=WRn=INTAn=1; IOMn=1, S1=S0=0; ad_oe=addr_oe=0; ad_out=haddress=0; rdata=0; cyc_ack=cyc_done=hlda=wait_timeout=0.
- Reset mid-cycle: strobes deassert on that same edge. No cyc_done pulse. The latched request is discarded.
- States: IDLE, T1, T2, TW, T3, T4, T5, T6, THOLD.
- Request acceptance: a request is accepted in IDLE, or on the final T-state edge (back-to-back cycles, zero idle clocks). The request is ignored if hold_q=1 (HOLD has priority) or if cyc_type is reserved (no ack).
- T1:
  - Latch type, addr and wdata.
  - ALE=1; ad_out=addr[7:0], ad_oe=1; haddress=addr[15:8], addr_oe=1.
  - Status IOMn/S1/S0: OF 011, MR 010, MW 001, IOR 110, IOW 101, INA 111.
- T2 and TW:
  - ALE=0.
  - Read types: RDn=0, ad_oe=0.
  - INA: INTAn=0, ad_oe=0.
  - Write types: WRn=0, ad_oe=1, ad_out=wdata.
  - ready is sampled at the end of T2 and of each TW: 1 leads to T3, 0 leads to TW.
  - The wait counter clears in T1 and increments per TW. If MAX_WAIT>0 and count==MAX_WAIT, go to T3 regardless of ready and set wait_timeout.
- T3:
  - Strobes stay asserted.
  - On the edge leaving T3: read/INA types load rdata<=ad_in, then all strobes deassert.
- T4 (OF/INA only): strobes high, ad_oe=0, address and status held.
- T5, T6: entered only if cyc_long; same outputs as T4.
- Final T-state: T3 for MR/MW/IOR/IOW; T4 for OF/INA; T6 if cyc_long.
- After the final T-state: cyc_done=1 for exactly one clock; rdata is valid from that clock until the next read completes. Next state is THOLD if hold_q, else T1 if there is a valid request, else IDLE.
- HOLD:
  - hold is synchronised by one flop (hold_q).
  - Taken only at a cycle boundary or in IDLE, never mid-cycle.
  - THOLD: hlda=1; ad_oe=addr_oe=0; RDn=WRn=INTAn=1; ALE=0.
  - hold_q=0 in THOLD: hlda drops on the next edge, and the state goes to T1 if a request is pending, else IDLE.
- IDLE: strobes high, ALE=0, ad_oe=0, addr_oe=1 with last haddress held.
- Simultaneous hold_q and cyc_req at a boundary: HOLD wins. The request stays pending (no ack).

Decomposition:
- Package bus_pkg:
  - mcycle_t enum
  - tstate_t enum (IDLE=0, T1..T6, TW, THOLD)
  - status constant array indexed by mcycle_t giving {IOMn,S1,S0}
  - helper functions is_read(), is_write(), has_t4()
- Single module; the wait counter and hold synchroniser are inline. No sub-module is needed.

Test Plan:
- MR at 0x1234, ready=1, ad_in=0xA5 in T3:
  - T1: ALE=1, ad_out=0x34, haddress=0x12, status 010.
  - T2–T3: RDn=0.
  - Next cycle: cyc_done=1, rdata=0xA5.
  - Total 3 clocks.
- MW of 0x5C to 0x00FF with ready low for 2 clocks: two TW states, WRn low for 4 clocks, ad_out=0x5C during T2..T3, cyc_done after T3.
- OF with cyc_long=0 then back-to-back OF with cyc_long=1: 4-clock then 6-clock cycles, no IDLE between, status 011, two cyc_done pulses 4 and 6 clocks apart.
- MAX_WAIT=3, ready stuck 0: exactly 3 TW, forced T3, wait_timeout=1 and stays 1 until resetn=0.
- hold asserted during T2 of an IOR with a second request pending:
  - The IOR completes.
  - THOLD with hlda=1 and all oe=0.
  - hold released: hlda=0, pending request acked in T1.
- resetn=0 during TW of MW: next edge WRn=1, ad_oe=0, state IDLE, no cyc_done.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: 8085 machine-cycle and T-state types, status encodings and cycle helpers.
package bus_pkg;

    typedef enum logic [2:0] {OF = 3'd0, MR, MW, IOR, IOW, INA} mcycle_t;
    typedef enum logic [3:0] {IDLE = 4'd0, T1, T2, T3, T4, T5, T6, TW, THOLD} tstate_t;

    // {IOMn,S1,S0} per cycle type; reserved codes map to the idle status
    localparam logic [2:0] STATUS [8] = '{3'b011, 3'b010, 3'b001, 3'b110,
                                          3'b101, 3'b111, 3'b100, 3'b100};

    function automatic logic is_read(input mcycle_t t);
        return t == OF || t == MR || t == IOR;
    endfunction

    function automatic logic is_write(input mcycle_t t);
        return t == MW || t == IOW;
    endfunction

    function automatic logic has_t4(input mcycle_t t);
        return t == OF || t == INA;
    endfunction

endpackage

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: 8085 T-state sequencer driving bus strobes, status, AD/address enables,
// READY wait states and HOLD/HLDA handover.
module bus_cycle_ctrl
    import bus_pkg::*;
#(
    parameter int MAX_WAIT   = 0,
    parameter int WAIT_CNT_W = 4
) (
    input  logic        phi1,
    input  logic        resetn,
    input  logic        cyc_req,
    input  logic [2:0]  cyc_type,
    input  logic        cyc_long,
    input  logic [15:0] cyc_addr,
    input  logic [7:0]  cyc_wdata,
    output logic        cyc_ack,
    output logic        cyc_done,
    output logic [7:0]  rdata,
    output logic        wait_timeout,
    input  logic [7:0]  ad_in,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    output logic [7:0]  haddress,
    output logic        addr_oe,
    output logic        ALE,
    output logic        RDn,
    output logic        WRn,
    output logic        INTAn,
    output logic        IOMn,
    output logic        S1,
    output logic        S0,
    input  logic        ready,
    input  logic        hold,
    output logic        hlda,
    output logic [3:0]  tstate
);

    tstate_t               st, nxt;
    mcycle_t               typ;
    logic                  lng;
    logic [7:0]            wdata;
    logic [WAIT_CNT_W-1:0] wcnt;
    logic                  hold_q, acc_ok, fin, bnd, tmo, acc, dp;

    assign tstate = st;

    always_comb begin
        acc_ok = cyc_req && (cyc_type < 3'd6) && !hold_q;
        fin    = (st == T3 && !has_t4(typ)) || (st == T4 && !lng) || st == T6;
        bnd    = fin || st == IDLE || st == THOLD;
        tmo    = (MAX_WAIT != 0) && (wcnt == WAIT_CNT_W'(MAX_WAIT));
        nxt    = IDLE;
        if (bnd)
            nxt = hold_q ? THOLD : acc_ok ? T1 : IDLE;
        else
            case (st)
                T1:      nxt = T2;
                T2, TW:  nxt = (ready || tmo) ? T3 : TW;
                T3:      nxt = T4;
                T4:      nxt = T5;
                T5:      nxt = T6;
                default: nxt = IDLE;
            endcase
        acc = bnd && nxt == T1;
        dp  = nxt == T2 || nxt == TW || nxt == T3;
    end

    always_ff @(posedge phi1) begin
        if (!resetn) begin
            st           <= IDLE;
            typ          <= OF;
            lng          <= 1'b0;
            wdata        <= '0;
            wcnt         <= '0;
            hold_q       <= 1'b0;
            cyc_ack      <= 1'b0;
            cyc_done     <= 1'b0;
            rdata        <= '0;
            wait_timeout <= 1'b0;
            ad_out       <= '0;
            ad_oe        <= 1'b0;
            haddress     <= '0;
            addr_oe      <= 1'b0;
            ALE          <= 1'b0;
            RDn          <= 1'b1;
            WRn          <= 1'b1;
            INTAn        <= 1'b1;
            {IOMn, S1, S0} <= 3'b100;
            hlda         <= 1'b0;
        end else begin
            st       <= nxt;
            hold_q   <= hold;
            cyc_ack  <= acc;
            cyc_done <= fin;
            hlda     <= nxt == THOLD;
            ALE      <= nxt == T1;
            addr_oe  <= nxt != THOLD;
            RDn      <= !(dp && is_read(typ));
            WRn      <= !(dp && is_write(typ));
            INTAn    <= !(dp && typ == INA);
            ad_oe    <= nxt == T1 || (dp && is_write(typ));
            ad_out   <= (nxt == T1) ? cyc_addr[7:0] : (dp && is_write(typ)) ? wdata : ad_out;
            if (acc) begin
                typ            <= mcycle_t'(cyc_type);
                lng            <= cyc_long;
                wdata          <= cyc_wdata;
                haddress       <= cyc_addr[15:8];
                {IOMn, S1, S0} <= STATUS[cyc_type];
            end
            wcnt <= acc ? '0 : (nxt == TW) ? wcnt + 1'b1 : wcnt;
            if ((st == T2 || st == TW) && !ready && tmo)
                wait_timeout <= 1'b1;
            if (st == T3 && (is_read(typ) || typ == INA))
                rdata <= ad_in;
        end
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb_bus_cycle_ctrl: directed T-state sequence checks for bus_cycle_ctrl with MAX_WAIT=3.
module tb_bus_cycle_ctrl;

    logic        phi1 = 1'b0, resetn, cyc_req, cyc_long, ready, hold;
    logic [2:0]  cyc_type;
    logic [15:0] cyc_addr;
    logic [7:0]  cyc_wdata, ad_in;
    logic        cyc_ack, cyc_done, wait_timeout, ad_oe, addr_oe;
    logic        ALE, RDn, WRn, INTAn, IOMn, S1, S0, hlda;
    logic [7:0]  rdata, ad_out, haddress;
    logic [3:0]  tstate;
    int          checks = 0, errors = 0;

    bus_cycle_ctrl #(.MAX_WAIT(3), .WAIT_CNT_W(4)) dut (
        .phi1(phi1), .resetn(resetn), .cyc_req(cyc_req), .cyc_type(cyc_type),
        .cyc_long(cyc_long), .cyc_addr(cyc_addr), .cyc_wdata(cyc_wdata),
        .cyc_ack(cyc_ack), .cyc_done(cyc_done), .rdata(rdata), .wait_timeout(wait_timeout),
        .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .haddress(haddress),
        .addr_oe(addr_oe), .ALE(ALE), .RDn(RDn), .WRn(WRn), .INTAn(INTAn),
        .IOMn(IOMn), .S1(S1), .S0(S0), .ready(ready), .hold(hold), .hlda(hlda),
        .tstate(tstate)
    );

    always #5 phi1 = ~phi1;

    task automatic tick();
        @(posedge phi1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [2:0] t, input logic [15:0] a, input logic [7:0] d, input logic l);
        cyc_req = 1'b1; cyc_type = t; cyc_addr = a; cyc_wdata = d; cyc_long = l;
    endtask

    initial begin
        resetn = 1'b0; cyc_req = 1'b0; cyc_type = 3'd0; cyc_long = 1'b0;
        cyc_addr = '0; cyc_wdata = '0; ad_in = '0; ready = 1'b1; hold = 1'b0;
        tick(); tick();
        chk("rst_state", 16'(tstate), 16'd0);
        chk("rst_strobes", {13'd0, RDn, WRn, INTAn}, 16'h7);
        chk("rst_status", {13'd0, IOMn, S1, S0}, 16'h4);
        chk("rst_oe", {13'd0, ALE, ad_oe, addr_oe}, 16'h0);
        chk("rst_flags", {12'd0, cyc_ack, cyc_done, hlda, wait_timeout}, 16'h0);
        chk("rst_rdata", 16'(rdata), 16'h0);
        resetn = 1'b1;
        // memory read, no waits
        req(3'd1, 16'h1234, 8'h00, 1'b0);
        tick();
        chk("mr_t1_state", 16'(tstate), 16'd1);
        chk("mr_t1_ale_ack", {14'd0, ALE, cyc_ack}, 16'h3);
        chk("mr_t1_addr", {haddress, ad_out}, 16'h1234);
        chk("mr_t1_status", {13'd0, IOMn, S1, S0}, 16'h2);
        chk("mr_t1_oe", {14'd0, ad_oe, addr_oe}, 16'h3);
        cyc_req = 1'b0;
        tick();
        chk("mr_t2", {12'd0, ALE, RDn, ad_oe, WRn}, 16'h1);
        ad_in = 8'hA5;
        tick();
        chk("mr_t3", {12'(tstate), 3'd0, RDn}, 16'h30);
        tick();
        chk("mr_done", {8'(rdata), 6'd0, cyc_done, RDn}, 16'hA503);
        chk("mr_idle", 16'(tstate), 16'd0);
        tick();
        chk("mr_done_pulse", 16'(cyc_done), 16'd0);
        // memory write with two wait states
        req(3'd2, 16'h00FF, 8'h5C, 1'b0);
        ready = 1'b0;
        tick();
        chk("mw_t1", {haddress, ad_out}, 16'h00FF);
        chk("mw_status", {13'd0, IOMn, S1, S0}, 16'h1);
        cyc_req = 1'b0;
        tick();
        chk("mw_t2", {ad_out, 5'd0, WRn, ad_oe, RDn}, 16'h5C03);
        tick();
        chk("mw_tw1", {12'(tstate), 3'd0, WRn}, 16'h70);
        tick();
        chk("mw_tw2", {12'(tstate), 3'd0, WRn}, 16'h70);
        ready = 1'b1;
        tick();
        chk("mw_t3", {ad_out, 3'd0, tstate, WRn}, 16'h5C06);
        tick();
        chk("mw_done", {13'd0, cyc_done, WRn, wait_timeout}, 16'h6);
        // reserved type is never acknowledged
        req(3'd6, 16'hBEEF, 8'h00, 1'b0);
        tick();
        chk("rsv_noack", {11'd0, cyc_ack, tstate}, 16'h0);
        tick();
        chk("rsv_idle_addr", {haddress, 7'd0, addr_oe}, 16'h0001);
        // back-to-back opcode fetches, 4-T then 6-T
        req(3'd0, 16'h0100, 8'h00, 1'b0);
        tick();
        chk("of1_t1", {11'd0, cyc_ack, tstate}, 16'h11);
        chk("of1_status", {13'd0, IOMn, S1, S0}, 16'h3);
        req(3'd0, 16'h0200, 8'h00, 1'b1);
        ad_in = 8'h3E;
        tick();
        chk("of1_t2", {12'(tstate), 3'd0, RDn}, 16'h20);
        tick();
        chk("of1_t3", {12'(tstate), 3'd0, RDn}, 16'h30);
        tick();
        chk("of1_t4", {12'(tstate), 2'd0, RDn, ad_oe}, 16'h42);
        tick();
        chk("of2_t1", {10'd0, cyc_done, cyc_ack, tstate}, 16'h31);
        chk("of2_addr", {haddress, ad_out}, 16'h0200);
        chk("of1_rdata", 16'(rdata), 16'h003E);
        cyc_req = 1'b0;
        ad_in = 8'h77;
        tick(); tick(); tick();
        chk("of2_t4", {11'd0, cyc_done, tstate}, 16'h4);
        tick();
        chk("of2_t5", {12'(tstate), 2'd0, RDn, ad_oe}, 16'h52);
        tick();
        chk("of2_t6", {11'd0, cyc_done, tstate}, 16'h6);
        tick();
        chk("of2_done", {11'd0, cyc_done, tstate}, 16'h10);
        chk("of2_rdata", 16'(rdata), 16'h0077);
        // wait-state limit forces T3
        req(3'd1, 16'h0042, 8'h00, 1'b0);
        ready = 1'b0;
        tick();
        cyc_req = 1'b0;
        tick();
        tick();
        chk("to_tw1", {11'd0, wait_timeout, tstate}, 16'h7);
        tick();
        tick();
        chk("to_tw3", {11'd0, wait_timeout, tstate}, 16'h7);
        tick();
        chk("to_t3", {11'd0, wait_timeout, tstate}, 16'h13);
        tick();
        chk("to_done", {10'd0, cyc_done, wait_timeout, tstate}, 16'h30);
        ready = 1'b1;
        tick();
        chk("to_sticky", 16'(wait_timeout), 16'd1);
        // HOLD during an I/O read with another request pending
        req(3'd3, 16'h0080, 8'h00, 1'b0);
        tick();
        chk("ior_status", {13'd0, IOMn, S1, S0}, 16'h6);
        req(3'd4, 16'h0090, 8'h77, 1'b0);
        tick();
        hold = 1'b1;
        ad_in = 8'h66;
        tick();
        chk("ior_t3", {12'(tstate), 3'd0, hlda}, 16'h30);
        tick();
        chk("hold_enter", {10'd0, cyc_done, cyc_ack, tstate}, 16'h28);
        chk("hold_pins", {11'd0, hlda, ad_oe, addr_oe, ALE, RDn}, 16'h11);
        chk("ior_rdata", 16'(rdata), 16'h0066);
        tick();
        chk("hold_stay", {11'd0, hlda, tstate}, 16'h18);
        hold = 1'b0;
        tick();
        chk("hold_sync", {11'd0, hlda, tstate}, 16'h18);
        tick();
        chk("hold_exit", {10'd0, hlda, cyc_ack, tstate}, 16'h11);
        chk("iow_status", {13'd0, IOMn, S1, S0}, 16'h5);
        cyc_req = 1'b0;
        tick();
        chk("iow_t2", {ad_out, 6'd0, WRn, ad_oe}, 16'h7701);
        tick(); tick();
        chk("iow_done", {14'd0, cyc_done, WRn}, 16'h3);
        // reset in the middle of a write wait state
        req(3'd2, 16'h0010, 8'h11, 1'b0);
        ready = 1'b0;
        tick();
        cyc_req = 1'b0;
        tick(); tick();
        chk("rmw_tw", {12'(tstate), 3'd0, WRn}, 16'h70);
        resetn = 1'b0;
        tick();
        chk("rmw_rst", {8'd0, tstate, WRn, ad_oe, cyc_done, wait_timeout}, 16'h0008);
        resetn = 1'b1;
        ready = 1'b1;
        tick();
        chk("rmw_after", {11'd0, cyc_done, tstate}, 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1);
    end

endmodule
